// File: rtl/mips_mult_div_pkg.sv
// Shared definitions for the iterative MIPS multiply/divide unit:
// op encodings, FSM state enum and iteration constants.
package mips_mult_div_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned ITER_COUNT = 32;
   localparam int unsigned CNT_W      = $clog2(ITER_COUNT);

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_e;

endpackage

// File: rtl/mips_mult_div_step.sv
// Single iteration of the multiply/divide datapath (purely combinational).
// Optional feature macro: MIPS_MULT_DIV_DIVIDE_EN (adds the divide step).
// Ports:
//   acc_i     {upper, lower} accumulator
//   operand_i multiplicand (multiply) or divisor (divide), as a magnitude
//   is_div_i  selects the divide step (only with MIPS_MULT_DIV_DIVIDE_EN)
//   acc_o     next accumulator; for divide, bit 0 is left 0
//   q_bit_o   quotient bit produced by a divide step (0 for multiply)
module mips_mult_div_step
   import mips_mult_div_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W
) (
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   operand_i,
`ifdef MIPS_MULT_DIV_DIVIDE_EN
   input  logic               is_div_i,
`endif
   output logic [2*WIDTH-1:0] acc_o,
   output logic               q_bit_o
);

   logic [WIDTH:0]     sum_c;
   logic [2*WIDTH-1:0] mul_acc_c;

   // Shift-add: conditionally add multiplicand to the upper half, shift right.
   always_comb begin
      sum_c     = {1'b0, acc_i[2*WIDTH-1:WIDTH]};
      if (acc_i[0]) sum_c = sum_c + {1'b0, operand_i};
      mul_acc_c = {sum_c, acc_i[WIDTH-1:1]};
   end

`ifdef MIPS_MULT_DIV_DIVIDE_EN
   logic [WIDTH:0]   trial_c;
   logic [WIDTH:0]   diff_c;
   logic             ge_c;
   logic [WIDTH-1:0] rem_c;

   // Restoring step: shift the next dividend bit into the remainder and
   // subtract when it fits. A 33-bit compare keeps divide-by-zero correct.
   always_comb begin
      trial_c = acc_i[2*WIDTH-1:WIDTH-1];
      diff_c  = trial_c - {1'b0, operand_i};
      ge_c    = (trial_c >= {1'b0, operand_i});
      rem_c   = ge_c ? diff_c[WIDTH-1:0] : trial_c[WIDTH-1:0];
      if (is_div_i) begin
         acc_o   = {rem_c, acc_i[WIDTH-2:0], 1'b0};
         q_bit_o = ge_c;
      end else begin
         acc_o   = mul_acc_c;
         q_bit_o = 1'b0;
      end
   end
`else
   always_comb begin
      acc_o   = mul_acc_c;
      q_bit_o = 1'b0;
   end
`endif

endmodule

// File: rtl/mips_mult_div.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Optional feature macro: MIPS_MULT_DIV_DIVIDE_EN (DIVU/DIV support; when
// undefined, divide starts are ignored and the divide datapath is absent).
// Ports:
//   cclk, rstb      clock, async active-low reset
//   start, op       issue request and operation (MULTU/MULT/DIVU/DIV)
//   rs_val, rt_val  operands, sampled only on the accepted start edge
//   busy            operation in progress
//   done            one-cycle pulse when HI/LO are written
//   hi, lo          HI/LO registers
module mips_mult_div
   import mips_mult_div_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W
) (
   input  logic             cclk,
   input  logic             rstb,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               neg_res_q;
   logic               busy_q;
   logic               done_q;
`ifdef MIPS_MULT_DIV_DIVIDE_EN
   logic               is_div_q;
   logic               neg_rem_q;
   logic               div0_q;
`endif

   logic               signed_c;
   logic               is_div_c;
   logic               accept_c;
   logic               a_neg_c;
   logic               b_neg_c;
   logic [WIDTH-1:0]   a_mag_c;
   logic [WIDTH-1:0]   b_mag_c;
   logic [2*WIDTH-1:0] prod_c;
   logic [WIDTH-1:0]   hi_fix_c;
   logic [WIDTH-1:0]   lo_fix_c;
   logic [2*WIDTH-1:0] step_acc_c;
   logic               step_q_c;

   // Issue decode: operand magnitudes and result signs for signed ops.
   always_comb begin
      signed_c = (op == OP_MULT) || (op == OP_DIV);
      is_div_c = (op == OP_DIVU) || (op == OP_DIV);
`ifdef MIPS_MULT_DIV_DIVIDE_EN
      accept_c = start;
`else
      accept_c = start && !is_div_c;
`endif
      a_neg_c  = signed_c && rs_val[WIDTH-1];
      b_neg_c  = signed_c && rt_val[WIDTH-1];
      a_mag_c  = a_neg_c ? -rs_val : rs_val;
      b_mag_c  = b_neg_c ? -rt_val : rt_val;
   end

   // Sign correction applied in FIX.
   always_comb begin
      prod_c   = neg_res_q ? -acc_q : acc_q;
      hi_fix_c = prod_c[2*WIDTH-1:WIDTH];
      lo_fix_c = prod_c[WIDTH-1:0];
`ifdef MIPS_MULT_DIV_DIVIDE_EN
      if (is_div_q) begin
         // Remainder follows the dividend sign; a zero divisor leaves
         // |rs| there, so this also restores rs_val into HI.
         hi_fix_c = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
         if (div0_q)
            lo_fix_c = '1;
         else
            lo_fix_c = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      end
`endif
   end

   mips_mult_div_step #(.WIDTH(WIDTH)) u_step (
      .acc_i     (acc_q),
      .operand_i (opnd_q),
`ifdef MIPS_MULT_DIV_DIVIDE_EN
      .is_div_i  (is_div_q),
`endif
      .acc_o     (step_acc_c),
      .q_bit_o   (step_q_c)
   );

   // Control FSM, iteration counter and HI/LO registers.
   always_ff @(posedge cclk or negedge rstb) begin
      if (!rstb) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         neg_res_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef MIPS_MULT_DIV_DIVIDE_EN
         is_div_q  <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept_c) begin
                  acc_q     <= {{WIDTH{1'b0}}, a_mag_c};
                  opnd_q    <= b_mag_c;
                  neg_res_q <= a_neg_c ^ b_neg_c;
`ifdef MIPS_MULT_DIV_DIVIDE_EN
                  is_div_q  <= is_div_c;
                  neg_rem_q <= a_neg_c;
                  div0_q    <= (rt_val == '0);
`endif
                  cnt_q     <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= ST_RUN;
               end
            end
            ST_RUN: begin
               acc_q <= step_acc_c | (2*WIDTH)'(step_q_c);
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(ITER_COUNT - 1)) state_q <= ST_FIX;
            end
            ST_FIX: begin
               hi_q    <= hi_fix_c;
               lo_q    <= lo_fix_c;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
